// File: rtl/baud_timer_multimode.sv
// baud_timer_multimode
// Multi-mode timer built from a TL/TH register pair:
//   mode 00 : 5+W-bit counter (tl[4:0] low, th high; tl[W-1:5] untouched)
//   mode 01 : 2W-bit counter {th,tl}
//   mode 10 : W-bit tl counter, auto-reloaded from th on overflow
//   mode 11 : halt
// Overflow sets a sticky tf flag and raises ovf_pulse for one cycle,
// coincident with the wrapped count.
// Optional baud divider, enabled by defining BAUD_TIMER_BAUD_DIV_EN:
// a 5-bit counter of overflows producing baud_tick every 16th (smod=1)
// or 32nd (smod=0) overflow. Without the macro baud_tick is tied low.
module baud_timer_multimode #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tr,
    input  logic [1:0]   mode,
    input  logic         load,
    input  logic [W-1:0] tl_in,
    input  logic [W-1:0] th_in,
    input  logic         tf_clr,
    input  logic         smod,
    output logic [W-1:0] tl,
    output logic [W-1:0] th,
    output logic         tf,
    output logic         ovf_pulse,
    output logic         baud_tick
);

    localparam logic [1:0] MODE_13 = 2'b00;
    localparam logic [1:0] MODE_16 = 2'b01;
    localparam logic [1:0] MODE_8R = 2'b10;
    localparam logic [1:0] MODE_HALT = 2'b11;

    logic [W-1:0]   tl_reg;
    logic [W-1:0]   th_reg;
    logic [W-1:0]   tl_next;
    logic [W-1:0]   th_next;
    logic           tf_reg;
    logic           ovf_pulse_reg;
    logic           ovf_next;
    logic           count_en;
    logic [2*W-1:0] wide_sum;

    assign count_en = tr && (mode != MODE_HALT);
    assign wide_sum = {th_reg, tl_reg} + (2*W)'(1);

    // Next-count logic: load has priority over counting and never overflows.
    always_comb begin
        tl_next  = tl_reg;
        th_next  = th_reg;
        ovf_next = 1'b0;
        if (load) begin
            tl_next = tl_in;
            th_next = th_in;
        end else if (count_en) begin
            case (mode)
                MODE_13: begin
                    tl_next[4:0] = tl_reg[4:0] + 5'd1;
                    if (tl_reg[4:0] == 5'h1f) begin
                        th_next  = th_reg + W'(1);
                        ovf_next = &th_reg;
                    end
                end
                MODE_16: begin
                    {th_next, tl_next} = wide_sum;
                    ovf_next           = &{th_reg, tl_reg};
                end
                MODE_8R: begin
                    if (&tl_reg) begin
                        tl_next  = th_reg;
                        ovf_next = 1'b1;
                    end else begin
                        tl_next = tl_reg + W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Count registers, sticky flag (set beats clear) and overflow strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tl_reg        <= '0;
            th_reg        <= '0;
            tf_reg        <= 1'b0;
            ovf_pulse_reg <= 1'b0;
        end else begin
            tl_reg        <= tl_next;
            th_reg        <= th_next;
            ovf_pulse_reg <= ovf_next;
            if (ovf_next) begin
                tf_reg <= 1'b1;
            end else if (tf_clr) begin
                tf_reg <= 1'b0;
            end
        end
    end

    assign tl        = tl_reg;
    assign th        = th_reg;
    assign tf        = tf_reg;
    assign ovf_pulse = ovf_pulse_reg;

`ifdef BAUD_TIMER_BAUD_DIV_EN
    logic [4:0] div_reg;
    logic       baud_tick_reg;
    logic       tick_next;

    // The tick is decided on the overflow edge so it lines up with ovf_pulse.
    always_comb begin
        tick_next = ovf_next && (smod ? (div_reg[3:0] == 4'hf) : (div_reg == 5'h1f));
    end

    // Overflow divider; only reset clears it, load and tf_clr leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg       <= 5'd0;
            baud_tick_reg <= 1'b0;
        end else begin
            if (ovf_next) begin
                div_reg <= div_reg + 5'd1;
            end
            baud_tick_reg <= tick_next;
        end
    end

    assign baud_tick = baud_tick_reg;
`else
    logic unused_smod;
    assign unused_smod = smod;
    assign baud_tick   = 1'b0;
`endif

endmodule

// File: tb/tb_baud_timer_multimode.sv
// Self-checking bench for baud_timer_multimode: directed scenarios followed
// by a randomized phase, all compared against an arithmetic reference model.
module tb_baud_timer_multimode;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         tr;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] tl_in;
    logic [W-1:0] th_in;
    logic         tf_clr;
    logic         smod;
    logic [W-1:0] tl;
    logic [W-1:0] th;
    logic         tf;
    logic         ovf_pulse;
    logic         baud_tick;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint m_tl, m_th, m_div;
    bit     m_tf, m_ovf, m_tick;

    baud_timer_multimode #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tr        (tr),
        .mode      (mode),
        .load      (load),
        .tl_in     (tl_in),
        .th_in     (th_in),
        .tf_clr    (tf_clr),
        .smod      (smod),
        .tl        (tl),
        .th        (th),
        .tf        (tf),
        .ovf_pulse (ovf_pulse),
        .baud_tick (baud_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tl = 0; m_th = 0; m_div = 0;
        m_tf = 0; m_ovf = 0; m_tick = 0;
    endtask

    // One clock edge of the timer, expressed as plain arithmetic on counts.
    task automatic model_edge();
        longint full;
        longint v;
        full  = longint'(1) << W;
        m_ovf = 0;
        if (load) begin
            m_tl = longint'(tl_in);
            m_th = longint'(th_in);
        end else if (tr && mode != 2'b11) begin
            if (mode == 2'b00) begin
                v = m_th * 32 + (m_tl % 32) + 1;
                if (v == full * 32) begin
                    v = 0;
                    m_ovf = 1;
                end
                m_th = v / 32;
                m_tl = (m_tl / 32) * 32 + (v % 32);
            end else if (mode == 2'b01) begin
                v = m_th * full + m_tl + 1;
                if (v == full * full) begin
                    v = 0;
                    m_ovf = 1;
                end
                m_th = v / full;
                m_tl = v % full;
            end else begin
                if (m_tl == full - 1) begin
                    m_tl = m_th;
                    m_ovf = 1;
                end else begin
                    m_tl = m_tl + 1;
                end
            end
        end
        if (m_ovf) m_tf = 1;
        else if (tf_clr) m_tf = 0;
`ifdef BAUD_TIMER_BAUD_DIV_EN
        m_tick = 0;
        if (m_ovf) begin
            m_tick = smod ? ((m_div % 16) == 15) : (m_div == 31);
            m_div  = (m_div + 1) % 32;
        end
`else
        m_tick = 0;
`endif
    endtask

    task automatic check_all();
        chk("tl", 32'(tl), 32'(m_tl));
        chk("th", 32'(th), 32'(m_th));
        chk("tf", 32'(tf), 32'(m_tf));
        chk("ovf_pulse", 32'(ovf_pulse), 32'(m_ovf));
        chk("baud_tick", 32'(baud_tick), 32'(m_tick));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [W-1:0] save_tl;
        logic [W-1:0] save_th;
        int last;
        int nticks;

        rst = 1'b0; tr = 1'b0; mode = 2'b00; load = 1'b0;
        tl_in = '0; th_in = '0; tf_clr = 1'b0; smod = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // counting resumes on the first edge after reset release
        tr = 1'b1; mode = 2'b01;
        step();
        chk("resume_tl", 32'(tl), 32'd1);

        // asynchronous reset mid-count in mode 01, right after an overflow
        load = 1'b1; tl_in = '1; th_in = '1;
        step();
        load = 1'b0;
        step();
        chk("m01_ovf", 32'(ovf_pulse), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_tl", 32'(tl), 32'd0);
        chk("rst_th", 32'(th), 32'd0);
        chk("rst_tf", 32'(tf), 32'd0);
        chk("rst_ovf", 32'(ovf_pulse), 32'd0);
        chk("rst_tick", 32'(baud_tick), 32'd0);
        #2;
        rst = 1'b1;

        // mode 00: th=FF tl=1E
        mode = 2'b00; load = 1'b1; tl_in = W'(8'h1e); th_in = W'(8'hff); tf_clr = 1'b1;
        step();
        load = 1'b0; tf_clr = 1'b0; tr = 1'b1;
        step();
        chk("m00_e1_tl", 32'(tl), 32'h1f);
        step();
        chk("m00_e2_tl", 32'(tl), 32'h00);
        chk("m00_e2_th", 32'(th), 32'h00);
        chk("m00_e2_tf", 32'(tf), 32'd1);
        chk("m00_e2_ovf", 32'(ovf_pulse), 32'd1);
        step();
        chk("m00_e3_ovf", 32'(ovf_pulse), 32'd0);

        // mode 10: th=F0 tl=FE, reload period 16
        mode = 2'b10; load = 1'b1; tl_in = W'(8'hfe); th_in = W'(8'hf0); tf_clr = 1'b1;
        step();
        load = 1'b0; tf_clr = 1'b0;
        step();
        chk("m10_e1_tl", 32'(tl), 32'hff);
        step();
        chk("m10_e2_tl", 32'(tl), 32'hf0);
        chk("m10_e2_ovf", 32'(ovf_pulse), 32'd1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("m10_gap_ovf", 32'(ovf_pulse), 32'd0);
        end
        step();
        chk("m10_e18_ovf", 32'(ovf_pulse), 32'd1);
        chk("m10_e18_tl", 32'(tl), 32'hf0);
        chk("m10_e18_th", 32'(th), 32'hf0);

        // mode 01: overflow and tf_clr on the same edge, set wins
        mode = 2'b01; load = 1'b1; tl_in = '1; th_in = '1; tf_clr = 1'b1;
        step();
        load = 1'b0; tr = 1'b1; tf_clr = 1'b1;
        step();
        chk("m01_setwins_tf", 32'(tf), 32'd1);
        chk("m01_setwins_ovf", 32'(ovf_pulse), 32'd1);
        tr = 1'b0;
        step();
        chk("m01_clr_tf", 32'(tf), 32'd0);
        tf_clr = 1'b0;

        // mode 10 with th=FF overflows every edge: baud divider spacing
        mode = 2'b10; load = 1'b1; tl_in = '1; th_in = '1;
        step();
        load = 1'b0; tr = 1'b1;
        for (int s = 1; s >= 0; s--) begin
            smod   = s[0];
            last   = -1;
            nticks = 0;
            for (int i = 0; i < 96; i++) begin
                step();
                if (baud_tick === 1'b1) begin
`ifdef BAUD_TIMER_BAUD_DIV_EN
                    if (last >= 0) chk("baud_gap", 32'(i - last), s[0] ? 32'd16 : 32'd32);
`endif
                    last = i;
                    nticks++;
                end
            end
`ifdef BAUD_TIMER_BAUD_DIV_EN
            chk("baud_seen", 32'(nticks >= 2), 32'd1);
`else
            chk("baud_none", 32'(nticks), 32'd0);
`endif
        end

        // hold: mode 11 with tr=1, then mode 01 with tr=0, sitting at all-ones
        mode = 2'b11; load = 1'b1; tl_in = '1; th_in = '1;
        step();
        load = 1'b0; tr = 1'b1;
        save_tl = tl; save_th = th;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_tl", 32'(tl), 32'(save_tl));
            chk("halt_th", 32'(th), 32'(save_th));
            chk("halt_ovf", 32'(ovf_pulse), 32'd0);
        end
        mode = 2'b01; tr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("tr0_tl", 32'(tl), 32'(save_tl));
            chk("tr0_th", 32'(th), 32'(save_th));
            chk("tr0_ovf", 32'(ovf_pulse), 32'd0);
        end

        // randomized phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) smod = 1'($urandom_range(0, 1));
            tr     = ($urandom_range(0, 7) != 0);
            load   = ($urandom_range(0, 19) == 0);
            tf_clr = ($urandom_range(0, 7) == 0);
            tl_in  = W'($urandom);
            th_in  = ($urandom_range(0, 1) == 1) ? '1 : W'($urandom);
            if ($urandom_range(0, 1) == 1) tl_in = tl_in | W'(8'hf0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
